binning_2x2_ctrl: RTL
=====================

Name: binning_2x2_ctrl

Overview:
- Frame-synchronous controller in front of binning_2x2.
- Takes register-side configuration requests (enable, bypass) and applies them only at a frame start, so the filter never sees a partial frame or a mid-frame mode change.
- Gates the de/hs/vs stream into the filter and drives its bypass input.
- Measures input frame geometry and flags stream errors that break 2x2 binning.

Parameters:
- PIXEL_WIDTH, 8, data width of di_i/do_o.
- LINE_SIZE_MAX, 4096, max pixels per line; pixel counter width PW = $clog2(LINE_SIZE_MAX+1).
- FRAME_LINES_MAX, 4096, max lines per frame; line counter width LW = $clog2(FRAME_LINES_MAX+1).
- DEFAULT_EN, 1, active enable after reset.
- DEFAULT_BYPASS, 0, active bypass after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cfg_wr_i  in  1  one-cycle write strobe for cfg_en_i/cfg_bypass_i
- cfg_en_i  in  1  requested enable
- cfg_bypass_i  in  1  requested bypass
- cfg_pending_o  out  1  shadow config waiting for frame start
- cfg_ack_o  out  1  one-cycle pulse when shadow config is applied
- err_clr_i  in  1  clears sticky err_o
- di_i  in  PIXEL_WIDTH  pixel in
- de_i, hs_i, vs_i  in  1 each  de high = valid pixel; hs high = line blank; vs high = frame active
- do_o  out  PIXEL_WIDTH  pixel to filter
- de_o, hs_o, vs_o  out  1 each  gated stream to filter
- bypass_o  out  1  to binning_2x2.bypass
- frame_start_o  out  1  pulse on vs_i rise (accepted frame)
- frame_end_o  out  1  pulse on vs_i fall
- meas_vld_o  out  1  pulse with frame_end_o; width_o/height_o valid
- width_o  out  PW  pixels in first line of last frame
- height_o  out  LW  lines in last frame
- frame_cnt_o  out  16  completed input frames, wraps
- err_o  out  3  sticky: [0] line length mismatch, [1] line overflow, [2] odd width or height

Behaviour:
- Reset (async): state S_SYNC; de_o=0, hs_o=1, vs_o=0, do_o=0; en_act=DEFAULT_EN, bypass_o=DEFAULT_BYPASS; pending=0; all pulses, counters, err_o, width_o, height_o = 0.
- Edge detect: vs_d, de_d registered; vs_rise = vs_i&~vs_d; vs_fall = ~vs_i&vs_d; line_end = ~de_i&de_d.
- FSM:
  - S_SYNC: outputs forced blank; go to S_VBLANK the first cycle vs_i=0. Coming out of reset mid-frame therefore drops the rest of that frame.
  - S_VBLANK, on vs_rise: go to S_FRAME; frame_start_o=1; if pending, en_act<=shadow_en, bypass_o<=shadow_bypass, cfg_ack_o=1, pending<=0.
  - S_FRAME, on vs_fall: go to S_VBLANK; frame_end_o=meas_vld_o=1; frame_cnt_o++; latch width_o/height_o.
- Config handshake:
  - cfg_wr_i loads the shadow register and sets pending; the last write before a frame start wins.
  - A cfg_wr_i in the same cycle as the apply is captured and stays pending for the next frame. The apply uses shadow contents from the previous cycle.
- Gating:
  - en_eff = (apply ? shadow_en : en_act), and is 0 in S_SYNC.
  - Registered outputs: do_o<=di_i; de_o<=de_i&en_eff; vs_o<=vs_i&en_eff; hs_o<=hs_i|~en_eff. Latency 1 cycle.
  - bypass_o changes in the same output cycle as the first vs_o=1 of the new frame.
  - A disabled frame is fully blanked but still measured and counted.
- Measurement (S_FRAME only):
  - pix_cnt increments on de_i and saturates at LINE_SIZE_MAX; a de_i while saturated sets err_o[1].
  - On line_end: line_cnt++ (saturating at FRAME_LINES_MAX); first line stores ref_w; later lines with pix_cnt≠ref_w set err_o[0]; pix_cnt<=0.
  - A line still open at vs_fall is counted as ended.
  - At frame end, err_o[2] is set if ref_w or line count is odd. Counters clear on vs_rise.
- err_o is sticky and cleared by err_clr_i; a new error in the same cycle as err_clr_i wins (bit stays set).

Test Plan:
- Reset, 2 frames 8x8 ramp, defaults: do_o/de_o/hs_o/vs_o = inputs delayed 1 clk; meas_vld_o at each frame end with width_o=8, height_o=8; frame_cnt_o 1 then 2; err_o=0.
- cfg_wr_i bypass=1 mid frame 0: cfg_pending_o=1, bypass_o stays 0 through frame 0; at frame 1 vs rise cfg_ack_o pulses, bypass_o=1 with first vs_o=1, pending=0.
- cfg_wr_i en=0 then en=1 in successive frames: frame 1 output de_o=0, vs_o=0, hs_o=1 throughout; frame_cnt_o still increments; frame 2 passes.
- Lines 8,8,7,8…(8 lines): err_o=3'b001; width 7 x 8 lines: err_o[2]=1; err_clr_i -> 0; err_clr_i coincident with new mismatch -> bit remains 1.
- Release rst while vs_i=1 mid-frame: no de_o/vs_o until next vs rise; first meas_vld_o only after that full frame.
- LINE_SIZE_MAX=16, 17-pixel line: err_o[1]=1; width_o=16.

Source files
------------

// File: rtl/binning_2x2_ctrl.sv
// Frame-synchronous front-end for binning_2x2: gates the video stream,
// applies shadowed config at frame start, measures geometry, flags errors.
module binning_2x2_ctrl #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int LINE_SIZE_MAX   = 4096,
    parameter int FRAME_LINES_MAX = 4096,
    parameter bit DEFAULT_EN      = 1'b1,
    parameter bit DEFAULT_BYPASS  = 1'b0,
    localparam int PW = $clog2(LINE_SIZE_MAX + 1),
    localparam int LW = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_bypass_i,
    output logic                   cfg_pending_o,
    output logic                   cfg_ack_o,
    input  logic                   err_clr_i,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   bypass_o,
    output logic                   frame_start_o,
    output logic                   frame_end_o,
    output logic                   meas_vld_o,
    output logic [PW-1:0]          width_o,
    output logic [LW-1:0]          height_o,
    output logic [15:0]            frame_cnt_o,
    output logic [2:0]             err_o
);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_VBLANK = 2'd1,
        S_FRAME  = 2'd2
    } state_t;

    localparam logic [PW-1:0] PIX_MAX  = PW'(LINE_SIZE_MAX);
    localparam logic [LW-1:0] LINE_MAX = LW'(FRAME_LINES_MAX);

    state_t state, state_nxt;

    logic vs_d, de_d;
    logic vs_rise, vs_fall, line_end;

    logic en_act;
    logic shadow_en, shadow_bypass, pending;

    logic apply, start, fend, en_eff;

    logic [PW-1:0] pix_cnt, pix_nxt, ref_w, ref_nxt;
    logic [LW-1:0] line_cnt, line_inc, lines_nxt;
    logic in_frame, pix_sat, ovf, line_close, first_line, mism, odd;
    logic [2:0] err_new;

    assign vs_rise  = vs_i & ~vs_d;
    assign vs_fall  = ~vs_i & vs_d;
    assign line_end = ~de_i & de_d;

    assign cfg_pending_o = pending;

    // Edge-detect history for vs/de
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_d <= vs_i;
            de_d <= de_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SYNC;
        else     state <= state_nxt;
    end

    // FSM next state, frame events and effective enable
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        start     = 1'b0;
        fend      = 1'b0;
        en_eff    = en_act;
        unique case (state)
            S_SYNC: begin
                en_eff = 1'b0;
                if (!vs_i) state_nxt = S_VBLANK;
            end
            S_VBLANK: begin
                if (vs_rise) begin
                    state_nxt = S_FRAME;
                    start     = 1'b1;
                    apply     = pending;
                    if (pending) en_eff = shadow_en;
                end
            end
            S_FRAME: begin
                if (vs_fall) begin
                    state_nxt = S_VBLANK;
                    fend      = 1'b1;
                end
            end
            default: begin
                state_nxt = S_SYNC;
                en_eff    = 1'b0;
            end
        endcase
    end

    // Shadow config capture and frame-start apply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_en     <= DEFAULT_EN;
            shadow_bypass <= DEFAULT_BYPASS;
            pending       <= 1'b0;
            en_act        <= DEFAULT_EN;
            bypass_o      <= DEFAULT_BYPASS;
            cfg_ack_o     <= 1'b0;
        end else begin
            cfg_ack_o <= apply;
            if (apply) begin
                en_act   <= shadow_en;
                bypass_o <= shadow_bypass;
            end
            if (cfg_wr_i) begin
                shadow_en     <= cfg_en_i;
                shadow_bypass <= cfg_bypass_i;
                pending       <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Gated, one-cycle-delayed stream towards the filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_o <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b1;
            vs_o <= 1'b0;
        end else begin
            do_o <= di_i;
            de_o <= de_i & en_eff;
            vs_o <= vs_i & en_eff;
            hs_o <= hs_i | ~en_eff;
        end
    end

    // Geometry counting and error detection for the current cycle
    always_comb begin
        in_frame   = (state == S_FRAME);
        pix_sat    = (pix_cnt == PIX_MAX);
        pix_nxt    = pix_cnt;
        if (in_frame && de_i && !pix_sat) pix_nxt = pix_cnt + PW'(1);
        ovf        = in_frame & de_i & pix_sat;
        line_close = in_frame &
                     (line_end | (vs_fall & (pix_nxt != '0)));
        line_inc   = (line_cnt == LINE_MAX) ? line_cnt
                                            : line_cnt + LW'(1);
        lines_nxt  = line_close ? line_inc : line_cnt;
        first_line = (line_cnt == '0);
        ref_nxt    = (line_close && first_line) ? pix_nxt : ref_w;
        mism       = line_close & ~first_line & (pix_nxt != ref_w);
        odd        = fend & (ref_nxt[0] | lines_nxt[0]);
        err_new    = {odd, ovf, mism};
    end

    // Per-frame pixel/line counters, cleared at frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            ref_w    <= '0;
        end else if (start) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            ref_w    <= '0;
        end else if (in_frame) begin
            pix_cnt  <= line_close ? '0 : pix_nxt;
            line_cnt <= lines_nxt;
            ref_w    <= ref_nxt;
        end
    end

    // Frame pulses, measurement latch and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            meas_vld_o    <= 1'b0;
            width_o       <= '0;
            height_o      <= '0;
            frame_cnt_o   <= '0;
        end else begin
            frame_start_o <= start;
            frame_end_o   <= fend;
            meas_vld_o    <= fend;
            if (fend) begin
                width_o     <= ref_nxt;
                height_o    <= lines_nxt;
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

    // Sticky errors; a fresh error beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_o <= '0;
        else     err_o <= (err_clr_i ? 3'b000 : err_o) | err_new;
    end

endmodule
